rr_mux_4x1: RTL and testbench

RR_MUX_4X1 -- requirements
Module: rr_mux_4x1

---
 rtl/mux_pkg.sv | 6 +
 rtl/rr_arbiter_4.sv | 40 ++++
 rtl/rr_mux_4x1.sv | 81 ++++++++
 tb/tb_rr_mux_4x1.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and the channel-index type for the 4:1 round-robin mux.
package mux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr+1, wrapping 3->0.
// ptr is owned here and moves to the winner only when advance (a real transfer) is high.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output sel_t            g
);

  sel_t r_ptr;
  sel_t w_idx;

  // Scan farthest-to-nearest so the channel closest after ptr overwrites the rest.
  always_comb begin
    grant = '0;
    g     = r_ptr;
    w_idx = r_ptr;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = sel_t'(r_ptr + k);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        g            = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= sel_t'(N_CH - 1);
    end else if (advance) begin
      r_ptr <= g;
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// 4:1 round-robin mux into one output register; 1-cycle latency, 1 word/cycle, drain+refill same cycle.
// Backpressure: in_ready is low while the register holds an unaccepted word or en is low. Option: RR_MUX_PARITY_EN adds out_par.
module rr_mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output sel_t                  out_sel,
`ifdef RR_MUX_PARITY_EN
  output logic                  out_par,
`endif
  input  logic                  out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  sel_t             r_out_sel;
  logic [N_CH-1:0]  w_grant;
  sel_t             w_g;
  logic             w_free;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_word;

  rr_arbiter_4 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (w_xfer),
    .grant   (w_grant),
    .g       (w_g)
  );

  // rst_n gates acceptance so in_ready reads zero for the whole reset window.
  assign w_free   = ~r_out_valid | out_ready;
  assign w_accept = en & w_free & rst_n;
  assign in_ready = w_accept ? w_grant : '0;
  assign w_xfer   = |in_ready;
  assign w_word   = in_data[w_g*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_free) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_word;
        r_out_sel  <= w_g;
      end
    end
  end

`ifdef RR_MUX_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= 1'b0;
    end else if (w_free && w_xfer) begin
      r_out_par <= ^w_word;
    end
  end

  assign out_par = r_out_par;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Scoreboard bench for rr_mux_4x1: a round-robin reference model predicts grants and words,
// a separate monitor pops predictions whenever the output handshakes.
module tb_rr_mux_4x1;
  import mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  sel_t        out_sel;
  logic        out_ready;
`ifdef RR_MUX_PARITY_EN
  logic        out_par;
`endif

  rr_mux_4x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef RR_MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         m_ptr;
  logic       m_held;
  logic [3:0] obs_rdy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First requesting channel after p, wrapping; -1 when nobody requests.
  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Entered just after a rising edge; drives one cycle of stimulus and predicts its effect.
  task automatic cycle(input logic e, input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int         gi;
    logic       free;
    logic [3:0] exp_rdy;
    en = e; in_valid = v; in_data = d; out_ready = ordy;
    @(negedge clk);
    free    = !m_held || ordy;
    gi      = rr_pick(m_ptr, v);
    exp_rdy = (e && free && gi >= 0) ? 4'(1 << gi) : 4'b0000;
    check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_held});
    obs_rdy = in_ready;
    if (free) m_held = (exp_rdy != 4'b0000);
    if (exp_rdy != 4'b0000) m_ptr = gi;
    @(posedge clk);
    if (exp_rdy != 4'b0000) sb.push_back('{d[gi*8 +: 8], 2'(gi)});
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sel", {30'd0, out_sel}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    sb.delete();
    m_held = 1'b0;
    m_ptr  = 3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom % 8) != 0, 4'($urandom), $urandom, ($urandom % 4) != 0);
    end
  endtask

  // Monitor: checks every output handshake against the scoreboard and stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  sel_t       prev_s;
  exp_t       got;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall && out_valid) begin
          check("hold_data", {24'd0, out_data}, {24'd0, prev_d});
          check("hold_sel", {30'd0, out_sel}, {30'd0, prev_s});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got word %0h sel %0d with nothing expected", out_data, out_sel);
          end else begin
            got = sb.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, got.d});
            check("out_sel", {30'd0, out_sel}, {30'd0, got.s});
`ifdef RR_MUX_PARITY_EN
            check("out_par", {31'd0, out_par}, {31'd0, ^got.d});
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_s     = out_sel;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    m_held = 1'b0; m_ptr = 3; obs_rdy = '0;
    #1;
    check("por_out_valid", {31'd0, out_valid}, 32'd0);
    check("por_in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: all channels requesting rotate 0,1,2,3,0.
    cycle(1, 4'b1111, 32'hA3A2A1A0, 1); check("fair0", {28'd0, obs_rdy}, 32'h1);
    cycle(1, 4'b1111, 32'hA3A2A1A0, 1); check("fair1", {28'd0, obs_rdy}, 32'h2);
    cycle(1, 4'b1111, 32'hA3A2A1A0, 1); check("fair2", {28'd0, obs_rdy}, 32'h4);
    cycle(1, 4'b1111, 32'hA3A2A1A0, 1); check("fair3", {28'd0, obs_rdy}, 32'h8);
    cycle(1, 4'b1111, 32'hA3A2A1A0, 1); check("fair4", {28'd0, obs_rdy}, 32'h1);

    // Backpressure: five stalled cycles, then the next word with no bubble.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 4'b1111, 32'hB3B2B1B0, 0); check("bp_stall_rdy", {28'd0, obs_rdy}, 32'h0);
    end
    cycle(1, 4'b1111, 32'hB3B2B1B0, 1); check("bp_resume_rdy", {28'd0, obs_rdy}, 32'h2);
    cycle(1, 4'b0000, 32'h0, 1);

    // Wrap and skip.
    do_reset();
    cycle(1, 4'b0010, 32'h44332211, 1); check("wrap_set_ptr1", {28'd0, obs_rdy}, 32'h2);
    cycle(1, 4'b0001, 32'h44332211, 1); check("wrap_to_0", {28'd0, obs_rdy}, 32'h1);
    cycle(1, 4'b1001, 32'h44332211, 1); check("skip_to_3", {28'd0, obs_rdy}, 32'h8);
    cycle(1, 4'b0000, 32'h0, 1);

    // Enable: held word drains while en is low, then channel 1 wins.
    do_reset();
    cycle(1, 4'b0001, 32'h0C0B0A07, 0);
    cycle(0, 4'b0110, 32'h0C0B0A03, 0); check("en_off_held", {28'd0, obs_rdy}, 32'h0);
    cycle(0, 4'b0110, 32'h0C0B0A03, 1); check("en_off_drain", {28'd0, obs_rdy}, 32'h0);
    cycle(0, 4'b0110, 32'h0C0B0A03, 1); check("en_off_empty", {28'd0, obs_rdy}, 32'h0);
    cycle(1, 4'b0110, 32'h0C0B0A03, 1); check("en_on_ch1", {28'd0, obs_rdy}, 32'h2);

    // Random traffic with a reset landing mid-stream.
    rand_cycles(200);
    in_valid = 4'b1111;
    do_reset();
    cycle(1, 4'b1111, $urandom, 1); check("post_rst_first", {28'd0, obs_rdy}, 32'h1);
    rand_cycles(200);

    for (int i = 0; i < 3; i++) cycle(1, 4'b0000, 32'h0, 1);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
